// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM state type and address-split width helpers for the instruction cache
package icache_pkg;
  typedef enum logic {IDLE, REQ} state_t;
  function automatic int off_w(input int words);
    return $clog2(words * 4);
  endfunction
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction
  function automatic int tag_w(input int lines, input int words);
    return 32 - off_w(words) - idx_w(lines);
  endfunction
endpackage

// File: rtl/icache_direct_if.sv
// icache_direct_if: fetch-port and line-fill bus; master is the cache, slave is core plus memory
interface icache_direct_if import icache_pkg::*; #(parameter int WORDS = 4);
  logic proc_read;
  logic [31:0] proc_addr;
  logic [31:0] proc_rdata;
  logic proc_stall;
  logic mem_read;
  logic [31-off_w(WORDS):0] mem_addr;
  logic [32*WORDS-1:0] mem_rdata;
  logic mem_ready;
  modport master(input proc_read, proc_addr, mem_rdata, mem_ready, output proc_rdata, proc_stall, mem_read, mem_addr);
  modport slave(output proc_read, proc_addr, mem_rdata, mem_ready, input proc_rdata, proc_stall, mem_read, mem_addr);
endinterface

// File: rtl/icache_tag_store.sv
// icache_tag_store: valid/tag/data arrays with one combinational read port and one synchronous write port
module icache_tag_store import icache_pkg::*; #(
  parameter int LINES = 8,
  parameter int WORDS = 4,
  parameter int TW = 25,
  parameter int IW = idx_w(LINES)
) (
  input  logic clk,
  input  logic rst,
  input  logic [IW-1:0] rd_idx,
  output logic rd_valid,
  output logic [TW-1:0] rd_tag,
  output logic [32*WORDS-1:0] rd_line,
  input  logic we,
  input  logic [IW-1:0] wr_idx,
  input  logic [TW-1:0] wr_tag,
  input  logic [32*WORDS-1:0] wr_line
);
  logic [LINES-1:0] valid;
  logic [TW-1:0] tags [LINES];
  logic [32*WORDS-1:0] data [LINES];
  assign rd_valid = valid[rd_idx];
  assign rd_tag = tags[rd_idx];
  assign rd_line = data[rd_idx];
  always_ff @(posedge clk)
    if (rst) valid <= '0;
    else if (we) valid[wr_idx] <= 1'b1;
  // tag and data carry no reset; the valid bit alone guards them
  always_ff @(posedge clk)
    if (we) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_line;
    end
endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache; ICACHE_PERF_EN adds hit/miss counters
module icache_direct import icache_pkg::*; #(
  parameter int LINES = 8,
  parameter int WORDS = 4
) (
  input logic clk,
  input logic rst,
  icache_direct_if.master bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
`endif
);
  localparam int OFF = off_w(WORDS);
  localparam int IW = idx_w(LINES);
  localparam int TW = tag_w(LINES, WORDS);
  state_t state;
  logic mem_read_q;
  logic [31-OFF:0] line_addr;
  logic [TW-1:0] tag;
  logic [IW-1:0] idx;
  logic [$clog2(WORDS)-1:0] wsel;
  logic rd_valid;
  logic [TW-1:0] rd_tag;
  logic [WORDS-1:0][31:0] rd_line;
  logic hit, miss;
  assign {tag, idx, wsel} = bus.proc_addr[31:2];
  assign hit = bus.proc_read && rd_valid && rd_tag == tag;
  assign miss = state == IDLE && bus.proc_read && !hit;
  assign bus.proc_stall = state == REQ || miss;
  assign bus.proc_rdata = state == IDLE && hit ? rd_line[wsel] : '0;
  assign bus.mem_read = mem_read_q;
  assign bus.mem_addr = line_addr;
  icache_tag_store #(.LINES(LINES), .WORDS(WORDS), .TW(TW)) store (
    .clk(clk),
    .rst(rst),
    .rd_idx(idx),
    .rd_valid(rd_valid),
    .rd_tag(rd_tag),
    .rd_line(rd_line),
    .we(mem_read_q && bus.mem_ready),
    .wr_idx(line_addr[IW-1:0]),
    .wr_tag(line_addr[31-OFF:IW]),
    .wr_line(bus.mem_rdata)
  );
  // the fill always completes once started; proc_read/proc_addr changes only matter back in IDLE
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      mem_read_q <= 1'b0;
      line_addr <= '0;
    end else if (state == IDLE) begin
      if (miss) begin
        state <= REQ;
        mem_read_q <= 1'b1;
        line_addr <= bus.proc_addr[31:OFF];
      end
    end else if (bus.mem_ready) begin
      state <= IDLE;
      mem_read_q <= 1'b0;
    end
`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk)
    if (rst) begin
      perf_hits <= '0;
      perf_misses <= '0;
    end else begin
      if (state == IDLE && hit && perf_hits != '1) perf_hits <= perf_hits + 32'd1;
      if (miss && perf_misses != '1) perf_misses <= perf_misses + 32'd1;
    end
`endif
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed vector table plus randomized traffic against a line-level cache model
module tb_icache_direct;
  import icache_pkg::*;
  typedef struct {
    logic r, rd;
    logic [31:0] a;
    logic rdy, s, m;
    logic [27:0] ma;
    logic [31:0] d;
    logic ck;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  icache_direct_if #(.WORDS(4)) bus();
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hits, perf_misses;
`endif
  icache_direct #(.LINES(8), .WORDS(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ICACHE_PERF_EN
    ,
    .perf_hits(perf_hits),
    .perf_misses(perf_misses)
`endif
  );
  function automatic logic [31:0] mw(input logic [31:0] a);
    logic [29:0] wa;
    wa = a[31:2];
    return {wa[24:0], 7'h13} ^ {7'h0, wa[29:5]};
  endfunction
  always_comb begin
    bus.mem_rdata = '0;
    for (int w = 0; w < 4; w++) bus.mem_rdata[32*w +: 32] = mw({bus.mem_addr, w[1:0], 2'b00});
  end
  bit m_valid [8];
  logic [24:0] m_tag [8];
  logic [31:0] m_data [8][4];
  bit m_pend;
  logic [27:0] m_pline;
  int m_hits, m_misses;
  function automatic bit m_hit(input logic rd, input logic [31:0] a);
    return rd && m_valid[a[6:4]] && m_tag[a[6:4]] == a[31:7];
  endfunction
  function automatic void m_step(input logic r, input logic rd, input logic [31:0] a, input logic rdy);
    if (r) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      m_pend = 0;
      m_hits = 0;
      m_misses = 0;
    end else if (m_pend) begin
      if (rdy) begin
        m_valid[m_pline[2:0]] = 1;
        m_tag[m_pline[2:0]] = m_pline[27:3];
        for (int w = 0; w < 4; w++) m_data[m_pline[2:0]][w] = mw({m_pline, w[1:0], 2'b00});
        m_pend = 0;
      end
    end else if (m_hit(rd, a)) m_hits++;
    else if (rd) begin
      m_misses++;
      m_pend = 1;
      m_pline = a[31:4];
    end
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic r, input logic rd, input logic [31:0] a, input logic rdy);
    @(posedge clk);
    #1;
    rst = r;
    bus.proc_read = rd;
    bus.proc_addr = a;
    bus.mem_ready = rdy;
    @(negedge clk);
  endtask
  function automatic vec_t mk(input logic r, rd, input logic [31:0] a, input logic rdy, s, m,
                              input logic [27:0] ma, input logic [31:0] d, input logic ck);
    vec_t v;
    v = '{r, rd, a, rdy, s, m, ma, d, ck};
    return v;
  endfunction
  vec_t tv [$];
  initial begin
    logic [24:0] tpool [3];
    logic r, rd, rdy;
    logic [31:0] a;
    int lat, cnt;
    bit h;
    tpool = '{25'h0, 25'h1, 25'h1abcde};
    bus.proc_read = 1'b0;
    bus.proc_addr = '0;
    bus.mem_ready = 1'b0;
    tv.push_back(mk(0, 0, 32'h00, 0, 0, 0, 28'h0, 32'h0, 1));
    tv.push_back(mk(0, 1, 32'h00, 0, 1, 0, 28'h0, 32'h0, 0));
    tv.push_back(mk(0, 1, 32'h00, 1, 1, 1, 28'h0, 32'h0, 0));
    tv.push_back(mk(0, 1, 32'h00, 0, 0, 0, 28'h0, 32'h13, 1));
    tv.push_back(mk(0, 1, 32'h04, 0, 0, 0, 28'h0, 32'h93, 1));
    tv.push_back(mk(0, 1, 32'h08, 0, 0, 0, 28'h0, 32'h113, 1));
    tv.push_back(mk(0, 1, 32'h0c, 0, 0, 0, 28'h0, 32'h193, 1));
    tv.push_back(mk(0, 1, 32'h80, 0, 1, 0, 28'h0, 32'h0, 0));
    tv.push_back(mk(0, 1, 32'h80, 1, 1, 1, 28'h8, 32'h0, 0));
    tv.push_back(mk(0, 1, 32'h80, 0, 0, 0, 28'h8, mw(32'h80), 1));
    tv.push_back(mk(0, 1, 32'h00, 0, 1, 0, 28'h8, 32'h0, 0));
    for (int i = 0; i < 4; i++) tv.push_back(mk(0, 1, 32'h00, 0, 1, 1, 28'h0, 32'h0, 0));
    tv.push_back(mk(0, 1, 32'h00, 1, 1, 1, 28'h0, 32'h0, 0));
    tv.push_back(mk(0, 1, 32'h00, 0, 0, 0, 28'h0, 32'h13, 1));
    tv.push_back(mk(0, 1, 32'h40, 0, 1, 0, 28'h0, 32'h0, 0));
    tv.push_back(mk(1, 1, 32'h40, 0, 1, 1, 28'h4, 32'h0, 0));
    tv.push_back(mk(0, 0, 32'h40, 1, 0, 0, 28'h0, 32'h0, 1));
    tv.push_back(mk(0, 1, 32'h40, 0, 1, 0, 28'h0, 32'h0, 0));
    tv.push_back(mk(0, 1, 32'h40, 1, 1, 1, 28'h4, 32'h0, 0));
    tv.push_back(mk(0, 1, 32'h00, 0, 1, 0, 28'h4, 32'h0, 0));
    tv.push_back(mk(0, 1, 32'h00, 1, 1, 1, 28'h0, 32'h0, 0));
    tv.push_back(mk(0, 1, 32'h40, 0, 0, 0, 28'h0, mw(32'h40), 1));
    tv.push_back(mk(0, 1, 32'h00, 0, 0, 0, 28'h0, 32'h13, 1));
    drive(1, 0, 0, 0);
    m_step(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    m_step(1, 0, 0, 0);
    foreach (tv[i]) begin
      drive(tv[i].r, tv[i].rd, tv[i].a, tv[i].rdy);
      chk($sformatf("vec%0d stall", i), 32'(bus.proc_stall), 32'(tv[i].s));
      chk($sformatf("vec%0d mem_read", i), 32'(bus.mem_read), 32'(tv[i].m));
      chk($sformatf("vec%0d mem_addr", i), 32'(bus.mem_addr), 32'(tv[i].ma));
      if (tv[i].ck) chk($sformatf("vec%0d rdata", i), bus.proc_rdata, tv[i].d);
`ifdef ICACHE_PERF_EN
      if (i == 7) begin
        chk("perf_hits", perf_hits, 32'd4);
        chk("perf_misses", perf_misses, 32'd1);
      end
`endif
      m_step(tv[i].r, tv[i].rd, tv[i].a, tv[i].rdy);
    end
    lat = 1;
    cnt = 0;
    a = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      r = $urandom_range(0, 99) == 0;
      rd = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 9) < 3)
        a = {tpool[$urandom_range(0, 2)], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
      if (bus.mem_read) begin
        cnt++;
        rdy = cnt >= lat;
      end else rdy = $urandom_range(0, 7) == 0;
      if (r || (rdy && bus.mem_read)) begin
        cnt = 0;
        lat = $urandom_range(1, 4);
      end
      rst = r;
      bus.proc_read = rd;
      bus.proc_addr = a;
      bus.mem_ready = rdy;
      @(negedge clk);
      h = m_hit(rd, a);
      chk("rnd mem_read", 32'(bus.mem_read), 32'(m_pend));
      chk("rnd stall", 32'(bus.proc_stall), 32'(m_pend || (rd && !h)));
      if (m_pend) chk("rnd mem_addr", 32'(bus.mem_addr), 32'(m_pline));
      else if (!rd || h) chk("rnd rdata", bus.proc_rdata, h ? m_data[a[6:4]][a[3:2]] : 32'h0);
`ifdef ICACHE_PERF_EN
      chk("rnd perf_hits", perf_hits, 32'(m_hits));
      chk("rnd perf_misses", perf_misses, 32'(m_misses));
`endif
      m_step(r, rd, a, rdy);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
